// File: rtl/game_tick_scheduler_pkg.sv
// Shared types and default divisors for the game tick scheduler.
package tetris_tick_pkg;

  // Game event identifiers offered on the event bus
  typedef enum logic [1:0] {
    EVT_DROP = 2'd0,
    EVT_MOVE = 2'd1,
    EVT_ANIM = 2'd2,
    EVT_RSVD = 2'd3
  } evt_id_e;

  // Event arbiter states
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_e;

  // Default divisors for the production CLK rate
  localparam int DEF_DISP_DIV  = 2501;
  localparam int DEF_MOVE_DIV  = 2500001;
  localparam int DEF_DROP_BASE = 25000001;
  localparam int DEF_DROP_STEP = 2000000;
  localparam int DEF_DROP_MIN  = 2500001;
  localparam int DEF_ANIM_DIV  = 25000001;
  localparam int DEF_LEVEL_W   = 4;
  localparam int DEF_CNT_W     = 25;

endpackage

// File: rtl/game_tick_scheduler_if.sv
// Valid/ready event bus from the tick scheduler to game logic.
interface game_tick_scheduler_if;
  import tetris_tick_pkg::*;

  logic    evt_valid;
  evt_id_e evt_id;
  logic    evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);

endinterface

// File: rtl/game_tick_scheduler_tick_counter.sv
// Period counter producing a single-cycle fire on wrap.
// Counts 0..period-1; the >= compare lets a shortened period act at once.
module tick_counter #(
  parameter int CNT_W = 25
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             hold,
  input  logic [CNT_W-1:0] period,
  output logic             fire
);

  logic [CNT_W-1:0] cnt_p1;
  logic             wrap_p0;

  assign wrap_p0 = ({1'b0, cnt_p1} + (CNT_W+1)'(1)) >= {1'b0, period};
  assign fire    = en & ~hold & wrap_p0;

  // Advance, hold, wrap or clear the period count
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          cnt_p1 <= '0;
    else if (!en)     cnt_p1 <= '0;
    else if (hold)    cnt_p1 <= cnt_p1;
    else if (wrap_p0) cnt_p1 <= '0;
    else              cnt_p1 <= cnt_p1 + 1'b1;
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Game tick scheduler: display strobe plus drop/move/anim events serialized
// onto a valid/ready bus, one event offered at a time.
// Optional build macro TICK_STATS_EN adds overrun_cnt and evt_cnt outputs.
module game_tick_scheduler
  import tetris_tick_pkg::*;
#(
  parameter int DISP_DIV  = DEF_DISP_DIV,
  parameter int MOVE_DIV  = DEF_MOVE_DIV,
  parameter int DROP_BASE = DEF_DROP_BASE,
  parameter int DROP_STEP = DEF_DROP_STEP,
  parameter int DROP_MIN  = DEF_DROP_MIN,
  parameter int ANIM_DIV  = DEF_ANIM_DIV,
  parameter int LEVEL_W   = DEF_LEVEL_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  input  logic                 pause,
  input  logic [LEVEL_W-1:0]   level,
  input  logic                 soft_drop,
  output logic                 disp_tick,
  game_tick_scheduler_if.master evt,
  output logic                 overrun,
  output logic [CNT_W-1:0]     drop_period
`ifdef TICK_STATS_EN
  ,
  output logic [7:0]           overrun_cnt,
  output logic [15:0]          evt_cnt
`endif
);

  localparam int WW = CNT_W + LEVEL_W;
  localparam logic [CNT_W-1:0] DISP_P = CNT_W'(DISP_DIV);
  localparam logic [CNT_W-1:0] MOVE_P = CNT_W'(MOVE_DIV);
  localparam logic [CNT_W-1:0] ANIM_P = CNT_W'(ANIM_DIV);
  localparam logic [CNT_W-1:0] BASE_P = CNT_W'(DROP_BASE);

  // Level-scaled drop period, clamped at DROP_MIN on underflow or undershoot
  function automatic logic [CNT_W-1:0] calc_drop_period(
    input logic [LEVEL_W-1:0] lvl,
    input logic               sd
  );
    logic [WW-1:0] base_w;
    logic [WW-1:0] prod_w;
    logic [WW-1:0] diff_w;
    base_w = WW'(DROP_BASE);
    prod_w = WW'(DROP_STEP) * WW'(lvl);
    diff_w = base_w - prod_w;
    if (sd)                         return MOVE_P;
    if (prod_w > base_w)            return CNT_W'(DROP_MIN);
    if (diff_w < WW'(DROP_MIN))     return CNT_W'(DROP_MIN);
    return CNT_W'(diff_w);
  endfunction

  // Fixed priority DROP > MOVE > ANIM
  function automatic evt_id_e pick_evt(input logic [2:0] pend);
    if (pend[EVT_DROP])      return EVT_DROP;
    else if (pend[EVT_MOVE]) return EVT_MOVE;
    else                     return EVT_ANIM;
  endfunction

  logic [3:0]  fire_p0;     // [0] drop, [1] move, [2] anim, [3] display
  logic [2:0]  grant_p0;
  logic        hs_p0;
  logic [2:0]  ovr_hit_p0;

  logic [2:0]  pend_p1;
  arb_state_e  state_p1;
  logic        vld_p1;
  evt_id_e     evt_id_p1;
  logic        disp_tick_p1;
  logic        overrun_p1;
  logic [CNT_W-1:0] drop_period_p1;

  tick_counter #(.CNT_W(CNT_W)) u_drop (
    .CLK(CLK), .RST(RST), .en(en), .hold(pause),
    .period(drop_period_p1), .fire(fire_p0[0])
  );
  tick_counter #(.CNT_W(CNT_W)) u_move (
    .CLK(CLK), .RST(RST), .en(en), .hold(pause),
    .period(MOVE_P), .fire(fire_p0[1])
  );
  tick_counter #(.CNT_W(CNT_W)) u_anim (
    .CLK(CLK), .RST(RST), .en(en), .hold(1'b0),
    .period(ANIM_P), .fire(fire_p0[2])
  );
  tick_counter #(.CNT_W(CNT_W)) u_disp (
    .CLK(CLK), .RST(RST), .en(en), .hold(1'b0),
    .period(DISP_P), .fire(fire_p0[3])
  );

  assign hs_p0      = (state_p1 == ARB_OFFER) & evt.evt_ready;
  assign grant_p0   = hs_p0 ? (3'b001 << evt_id_p1) : 3'b000;
  assign ovr_hit_p0 = fire_p0[2:0] & pend_p1 & ~grant_p0;

  // ---- stage p1: pending set/clear and sticky overrun ----
  // A fire on a channel being granted in the same cycle keeps it pending
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_p1    <= '0;
      overrun_p1 <= 1'b0;
    end else begin
      if (!en) pend_p1 <= '0;
      else     pend_p1 <= fire_p0[2:0] | (pend_p1 & ~grant_p0);
      if (|ovr_hit_p0) overrun_p1 <= 1'b1;
    end
  end

  // Arbiter: offer one pending event and hold it stable until accepted
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_p1  <= ARB_IDLE;
      vld_p1    <= 1'b0;
      evt_id_p1 <= EVT_DROP;
    end else if (!en) begin
      state_p1  <= ARB_IDLE;
      vld_p1    <= 1'b0;
    end else begin
      case (state_p1)
        ARB_IDLE: begin
          if (|pend_p1) begin
            evt_id_p1 <= pick_evt(pend_p1);
            vld_p1    <= 1'b1;
            state_p1  <= ARB_OFFER;
          end
        end
        ARB_OFFER: begin
          if (evt.evt_ready) begin
            vld_p1   <= 1'b0;
            state_p1 <= ARB_IDLE;
          end
        end
        default: begin
          vld_p1   <= 1'b0;
          state_p1 <= ARB_IDLE;
        end
      endcase
    end
  end

  // Registered display strobe and active drop period
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      disp_tick_p1   <= 1'b0;
      drop_period_p1 <= BASE_P;
    end else begin
      disp_tick_p1   <= en & fire_p0[3];
      drop_period_p1 <= calc_drop_period(level, soft_drop);
    end
  end

`ifdef TICK_STATS_EN
  // Saturating overrun count and wrapping handshake count
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overrun_cnt <= '0;
      evt_cnt     <= '0;
    end else begin
      if ((|ovr_hit_p0) && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
      if (hs_p0) evt_cnt <= evt_cnt + 16'd1;
    end
  end
`endif

  assign evt.evt_valid = vld_p1;
  assign evt.evt_id    = evt_id_p1;
  assign disp_tick     = disp_tick_p1;
  assign overrun       = overrun_p1;
  assign drop_period   = drop_period_p1;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler with small divisors. A cycle model predicts
// outputs; accepted events are queued from the model and popped on DUT
// handshakes. Build with TICK_STATS_EN to also cover the statistics ports.
module tb_game_tick_scheduler;
  import tetris_tick_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       en = 1'b1;
  logic       pause = 1'b0;
  logic [3:0] level = 4'd0;
  logic       soft_drop = 1'b0;
  logic       disp_tick;
  logic       overrun;
  logic [24:0] drop_period;
`ifdef TICK_STATS_EN
  logic [7:0]  overrun_cnt;
  logic [15:0] evt_cnt;
`endif

  game_tick_scheduler_if bus ();

  game_tick_scheduler #(
    .DISP_DIV(4), .MOVE_DIV(6), .DROP_BASE(20), .DROP_STEP(4),
    .DROP_MIN(6), .ANIM_DIV(10), .LEVEL_W(4), .CNT_W(25)
  ) dut (
    .CLK(CLK), .RST(RST), .en(en), .pause(pause), .level(level),
    .soft_drop(soft_drop), .disp_tick(disp_tick), .evt(bus),
    .overrun(overrun), .drop_period(drop_period)
`ifdef TICK_STATS_EN
    , .overrun_cnt(overrun_cnt), .evt_cnt(evt_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int       m_cnt [4];
  bit [2:0] m_pend;
  bit       m_valid;
  int       m_id;
  bit       m_ovr;
  bit       m_disp;
  int       m_dp;
  int       edge_n;

  int sb_q [$];
  int hs_log [0:255];
  int hs_total;
  int first_disp, second_disp, first_offer, first_offer_id;

  function automatic int model_dp(input int lvl, input bit sd);
    int v;
    if (sd) return 6;
    v = 20 - lvl * 4;
    if (v < 6) return 6;
    return v;
  endfunction

  // Cycle model of the scheduler in spec terms
  always @(posedge CLK or posedge RST) begin : model
    int per [4];
    int nc [4];
    bit f [4];
    bit hs, gr, held, no;
    bit [2:0] np;
    if (RST) begin
      m_cnt   <= '{default: 0};
      m_pend  <= '0;
      m_valid <= 1'b0;
      m_id    <= 0;
      m_ovr   <= 1'b0;
      m_disp  <= 1'b0;
      m_dp    <= 20;
      edge_n  <= 0;
    end else begin
      per[0] = m_dp; per[1] = 6; per[2] = 10; per[3] = 4;
      hs = m_valid && bus.evt_ready;
      no = m_ovr;
      for (int i = 0; i < 4; i++) begin
        held  = pause && (i < 2);
        f[i]  = en && !held && (m_cnt[i] + 1 >= per[i]);
        if (!en || f[i]) nc[i] = 0;
        else if (held)   nc[i] = m_cnt[i];
        else             nc[i] = m_cnt[i] + 1;
      end
      for (int i = 0; i < 3; i++) begin
        gr    = hs && (m_id == i);
        np[i] = f[i] || (m_pend[i] && !gr);
        if (f[i] && m_pend[i] && !gr) no = 1'b1;
      end
      if (!en) np = '0;
      m_cnt  <= nc;
      m_pend <= np;
      m_ovr  <= no;
      if (!en) m_valid <= 1'b0;
      else if (!m_valid) begin
        if (m_pend != 0) begin
          m_valid <= 1'b1;
          m_id    <= m_pend[0] ? 0 : (m_pend[1] ? 1 : 2);
        end
      end else if (hs) m_valid <= 1'b0;
      m_disp <= f[3];
      m_dp   <= model_dp(int'(level), soft_drop);
      edge_n <= edge_n + 1;
    end
  end

  // Per-cycle comparison and scoreboard, away from the active edge
  always @(negedge CLK) begin
    if (!RST) begin
      chk("evt_valid", bus.evt_valid, m_valid);
      chk("evt_id", 32'(bus.evt_id), m_id);
      chk("disp_tick", disp_tick, m_disp);
      chk("overrun", overrun, m_ovr);
      chk("drop_period", drop_period, m_dp);
      if (disp_tick) begin
        if (first_disp < 0) first_disp = edge_n;
        else if (second_disp < 0) second_disp = edge_n;
      end
      if (bus.evt_valid && first_offer < 0) begin
        first_offer    = edge_n;
        first_offer_id = 32'(bus.evt_id);
      end
      if (m_valid && bus.evt_ready) sb_q.push_back(m_id);
      if (bus.evt_valid && bus.evt_ready) begin
        hs_total++;
        if (edge_n + 1 < 256) hs_log[edge_n + 1] = 32'(bus.evt_id);
        if (sb_q.size() == 0) chk("sb_unexpected_evt", 1, 0);
        else chk("sb_evt_id", 32'(bus.evt_id), sb_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    en = 1'b1; pause = 1'b0; level = 4'd0; soft_drop = 1'b0;
    bus.evt_ready = 1'b1;
    cyc(2);
    chk("sb_drained", sb_q.size(), 0);
    sb_q.delete();
    for (int i = 0; i < 256; i++) hs_log[i] = -1;
    hs_total = 0;
    first_disp = -1; second_disp = -1; first_offer = -1; first_offer_id = -1;
    chk("rst_valid", bus.evt_valid, 0);
    chk("rst_id", 32'(bus.evt_id), 0);
    chk("rst_disp", disp_tick, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_drop_period", drop_period, 20);
    RST = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt_disp, cnt_anim, cnt_dm;
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 256; i++) hs_log[i] = -1;
    first_disp = -1; second_disp = -1; first_offer = -1; first_offer_id = -1;
    hs_total = 0;
    cyc(1);

    // Free run at level 0
    do_reset();
    cyc(70);
    chk("first_disp_edge", first_disp, 4);
    chk("second_disp_edge", second_disp, 8);
    chk("first_offer_edge", first_offer, 7);
    chk("first_offer_id", first_offer_id, EVT_MOVE);
    chk("hs22_drop", hs_log[22], EVT_DROP);
    chk("hs24_anim", hs_log[24], EVT_ANIM);
    chk("hs62_drop", hs_log[62], EVT_DROP);
    chk("hs64_move", hs_log[64], EVT_MOVE);
    chk("hs66_anim", hs_log[66], EVT_ANIM);
    chk("no_overrun", overrun, 0);
`ifdef TICK_STATS_EN
    chk("evt_cnt", evt_cnt, hs_total);
`endif

    // Drop period by level and soft drop
    level = 4'd5;  cyc(1); chk("dp_level5", drop_period, 6);
    level = 4'd2;  cyc(1); chk("dp_level2", drop_period, 12);
    soft_drop = 1; cyc(1); chk("dp_soft", drop_period, 6);
    soft_drop = 0; level = 4'd15; cyc(1); chk("dp_level15", drop_period, 6);
    level = 4'd0;  cyc(20);

    // Stalled consumer
    do_reset();
    bus.evt_ready = 1'b0;
    cyc(30);
    chk("stall_valid", bus.evt_valid, 1);
    chk("stall_id", 32'(bus.evt_id), EVT_MOVE);
    chk("stall_overrun", overrun, 1);
`ifdef TICK_STATS_EN
    chk("stall_ovr_cnt_nz", 32'(overrun_cnt != 0), 1);
`endif
    bus.evt_ready = 1'b1;
    cyc(20);
    chk("overrun_sticky", overrun, 1);

    // Global disable
    en = 1'b0;
    cyc(1);
    chk("en0_valid", bus.evt_valid, 0);
    chk("en0_disp", disp_tick, 0);
    cyc(5);
    chk("en0_overrun_kept", overrun, 1);
    en = 1'b1;
    cyc(12);

    // Pause
    do_reset();
    cyc(15);
    pause = 1'b1;
    cnt_disp = 0; cnt_anim = 0; cnt_dm = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (disp_tick) cnt_disp++;
      if (bus.evt_valid && bus.evt_ready) begin
        if (bus.evt_id == EVT_ANIM) cnt_anim++;
        else cnt_dm++;
      end
    end
    chk("pause_disp_cnt", cnt_disp, 13);
    chk("pause_anim_cnt", cnt_anim, 5);
    chk("pause_dropmove_cnt", cnt_dm, 0);
    pause = 1'b0;
    cyc(10);
    chk("resume_hs70_move", hs_log[70], EVT_MOVE);
    chk("resume_hs72_drop", hs_log[72], EVT_DROP);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      bus.evt_ready = ($urandom_range(0, 3) != 0);
      if (i % 25 == 0) begin
        level     = 4'($urandom_range(0, 15));
        soft_drop = ($urandom_range(0, 4) == 0);
      end
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      en = ($urandom_range(0, 49) != 0);
      cyc(1);
    end
    en = 1'b1; pause = 1'b0;

    // Reset in the middle of an offer
    do_reset();
    bus.evt_ready = 1'b0;
    cyc(20);
    begin : wait_offer
      for (int i = 0; i < 40 && !bus.evt_valid; i++) cyc(1);
    end
    chk("pre_rst_valid", bus.evt_valid, 1);
    chk("pre_rst_overrun", overrun, 1);
    #1 RST = 1'b1;
    #1;
    chk("midrst_valid", bus.evt_valid, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_id", 32'(bus.evt_id), 0);
`ifdef TICK_STATS_EN
    chk("midrst_ovr_cnt", overrun_cnt, 0);
    chk("midrst_evt_cnt", evt_cnt, 0);
`endif
    sb_q.delete();
    do_reset();
    cyc(12);
    chk("post_rst_first_offer", first_offer, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
